// File: rtl/sd_read_arbiter_if.sv
// sd_read_arbiter_if: requester-side and sd_spi-side signals of the read arbiter.
// slave = arbiter view, master = requesters plus sd_spi view.
interface sd_read_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        req_grant;
  logic [7:0]        byte_data;
  logic [1:0]        byte_valid;
  logic [1:0]        byte_ready;
  logic [1:0]        done;
  logic [1:0]        error;
  logic [2:0]        error_code;
  logic              active;
  logic              sd_rd;
  logic [ADDR_W-1:0] sd_addr;
  logic [7:0]        sd_dout;
  logic              sd_dout_avail;
  logic              sd_dout_taken;
  logic              sd_busy;
  logic              sd_error;
  logic [2:0]        sd_error_code;

  modport slave (
    input  req_valid, req_addr0, req_addr1, byte_ready,
    input  sd_dout, sd_dout_avail, sd_busy, sd_error, sd_error_code,
    output req_grant, byte_data, byte_valid, done, error,
    output error_code, active, sd_rd, sd_addr, sd_dout_taken
  );

  modport master (
    output req_valid, req_addr0, req_addr1, byte_ready,
    output sd_dout, sd_dout_avail, sd_busy, sd_error, sd_error_code,
    input  req_grant, byte_data, byte_valid, done, error,
    input  error_code, active, sd_rd, sd_addr, sd_dout_taken
  );
endinterface

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin share of the sd_spi single-block read port.
// Define SD_READ_ARB_TIMEOUT_EN to abort ISSUE when sd_busy never rises.
module sd_read_arbiter #(
  parameter int BLOCK_BYTES   = 512,
  parameter int ADDR_W        = 32,
  parameter int START_TIMEOUT = 4095
) (
  input logic              clk,
  input logic              reset,
  sd_read_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, STREAM, TAKE, DRAIN, DONE
  } state_t;

  state_t           state;
  logic             g;
  logic             last_grant;
  logic             err_flag;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             err_hit;

  if (START_TIMEOUT < 1) begin : g_bad_timeout
    $error("START_TIMEOUT must be at least 1");
  end

`ifdef SD_READ_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Round-robin choice: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    pick = 1'b0;
    case (bus.req_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
    err_hit = bus.sd_error &
              (state == ISSUE || state == STREAM || state == TAKE);
  end

  // Byte relay to the granted requester; an sd_error cycle hides the byte.
  always_comb begin
    bus.byte_valid = 2'b00;
    bus.byte_data  = 8'h00;
    if (state == STREAM && !bus.sd_error) begin
      bus.byte_valid[g] = bus.sd_dout_avail;
      bus.byte_data     = bus.sd_dout;
    end
  end

  // Transfer sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      g                 <= 1'b0;
      last_grant        <= 1'b1;
      err_flag          <= 1'b0;
      cnt               <= '0;
      bus.req_grant     <= 2'b00;
      bus.done          <= 2'b00;
      bus.error         <= 2'b00;
      bus.error_code    <= 3'b000;
      bus.active        <= 1'b0;
      bus.sd_rd         <= 1'b0;
      bus.sd_addr       <= '0;
      bus.sd_dout_taken <= 1'b0;
`ifdef SD_READ_ARB_TIMEOUT_EN
      to_cnt            <= '0;
`endif
    end else begin
      bus.req_grant <= 2'b00;
      bus.done      <= 2'b00;
      bus.error     <= 2'b00;
      if (err_hit) begin
        bus.error_code    <= bus.sd_error_code;
        err_flag          <= 1'b1;
        bus.sd_rd         <= 1'b0;
        bus.sd_dout_taken <= 1'b0;
        state             <= DRAIN;
      end else begin
        unique case (state)
          IDLE: begin
            if (!bus.sd_busy && (|bus.req_valid)) begin
              g             <= pick;
              last_grant    <= pick;
              bus.req_grant <= {pick, ~pick};
              bus.sd_addr   <= pick ? bus.req_addr1 : bus.req_addr0;
              bus.sd_rd     <= 1'b1;
              bus.active    <= 1'b1;
              state         <= ISSUE;
`ifdef SD_READ_ARB_TIMEOUT_EN
              to_cnt        <= '0;
`endif
            end
          end
          ISSUE: begin
            if (bus.sd_busy) begin
              bus.sd_rd <= 1'b0;
              state     <= STREAM;
            end
`ifdef SD_READ_ARB_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              bus.sd_rd      <= 1'b0;
              bus.error_code <= 3'b111;
              err_flag       <= 1'b1;
              state          <= DRAIN;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
`endif
          end
          STREAM: begin
            if (bus.sd_dout_avail && bus.byte_ready[g]) begin
              bus.sd_dout_taken <= 1'b1;
              state             <= TAKE;
            end
          end
          TAKE: begin
            if (!bus.sd_dout_avail) begin
              bus.sd_dout_taken <= 1'b0;
              cnt               <= cnt + 1'b1;
              state             <= (cnt == LAST) ? DRAIN : STREAM;
            end
          end
          DRAIN: begin
            if (!bus.sd_busy) begin
              bus.done  <= {g, ~g};
              bus.error <= err_flag ? {g, ~g} : 2'b00;
              state     <= DONE;
            end
          end
          DONE: begin
            cnt        <= '0;
            err_flag   <= 1'b0;
            bus.active <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: random requesters and a behavioural sd_spi model
// checked against a transaction-level reference of the arbiter.
module tb_sd_read_arbiter;
  localparam int BB = 512;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_read_arbiter_if #(.ADDR_W(AW)) bus ();

  sd_read_arbiter #(
    .BLOCK_BYTES(BB),
    .ADDR_W(AW),
    .START_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // sd model / requester configuration
  int          base = 0;
  int          err_at = -1;
  logic [2:0]  err_cd = 3'b000;
  bit          never_busy = 0;
  bit          abort = 0;
  bit          slow = 0;
  int          slow_cnt = 0;

  // reference expectations and observed transaction state
  bit          exp_err = 0;
  int          exp_cnt = BB;
  logic [2:0]  exp_code = 3'b000;
  bit          ref_last = 1;
  int          cur_g = 0;
  int          hs = 0;
  int          done_cnt = 0;
  int          rd_len = 0;
  int          grant_log[$];
  logic        prev_hs = 0;
  logic        prev_taken = 0;
  logic        prev_rd = 0;
  logic [1:0]  prev_rv = 2'b00;
  logic [31:0] pa0 = 0;
  logic [31:0] pa1 = 0;
  logic [31:0] cur_addr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural sd_spi: busy after rd, byte i = i+base, optional error.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.sd_rd && !bus.sd_busy && !never_busy && !abort) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.sd_busy = 1'b1;
        for (int i = 0; i < BB && !abort; i++) begin
          if (i == err_at) begin
            bus.sd_error_code = err_cd;
            bus.sd_error = 1'b1;
            @(negedge clk);
            bus.sd_error = 1'b0;
            break;
          end
          repeat ($urandom_range(0, 2)) @(negedge clk);
          bus.sd_dout = 8'(i + base);
          bus.sd_dout_avail = 1'b1;
          do @(negedge clk); while (!bus.sd_dout_taken && !abort);
          bus.sd_dout_avail = 1'b0;
          do @(negedge clk); while (bus.sd_dout_taken && !abort);
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.sd_busy = 1'b0;
      end
    end
  end

  // Requester consume side: random ready, or 20 idle cycles per byte.
  initial begin
    forever begin
      @(negedge clk);
      if (slow) begin
        if (slow_cnt < 20) begin
          bus.byte_ready = 2'b00;
          slow_cnt++;
        end else begin
          bus.byte_ready = 2'b11;
        end
      end else begin
        bus.byte_ready = {($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0)};
      end
    end
  end

  // Monitor: compares every grant, byte and completion with the reference.
  initial begin
    int  e;
    logic hs_now;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        ref_last = 1;
        prev_hs = 0;
        prev_taken = 0;
        prev_rd = 0;
      end else begin
        if (bus.req_grant != 2'b00) begin
          if (prev_rv == 2'b11) e = ref_last ? 0 : 1;
          else e = prev_rv[1] ? 1 : 0;
          check("grant_had_req", 32'(prev_rv != 2'b00), 1);
          check("grant", bus.req_grant, 32'(1 << e));
          check("active_at_grant", bus.active, 1);
          ref_last = e[0];
          cur_g = e;
          hs = 0;
          cur_addr = e ? pa1 : pa0;
          grant_log.push_back(e);
        end
        if (bus.sd_rd && !prev_rd) begin
          check("sd_addr", bus.sd_addr, cur_addr);
          rd_len = 1;
        end else if (bus.sd_rd) begin
          rd_len++;
        end
        if (bus.byte_valid != 2'b00)
          check("bv_mask", bus.byte_valid, 32'(1 << cur_g));
        hs_now = bus.byte_valid[cur_g] && bus.byte_ready[cur_g];
        if (hs_now) begin
          check("byte", bus.byte_data, (hs + base) & 255);
          hs++;
          slow_cnt = 0;
        end
        if (bus.sd_dout_taken && !prev_taken)
          check("taken_after_hs", prev_hs, 1);
        if (bus.done != 2'b00) begin
          check("done", bus.done, 32'(1 << cur_g));
          check("error", bus.error, exp_err ? 32'(1 << cur_g) : 0);
          check("bytes", hs, exp_cnt);
          check("addr_at_done", bus.sd_addr, cur_addr);
          if (exp_err) check("error_code", bus.error_code, exp_code);
          done_cnt++;
        end else if (bus.error != 2'b00) begin
          check("error_without_done", bus.error, 0);
        end
        prev_hs = hs_now;
        prev_taken = bus.sd_dout_taken;
        prev_rd = bus.sd_rd;
      end
      prev_rv = bus.req_valid;
      pa0 = bus.req_addr0;
      pa1 = bus.req_addr1;
    end
  end

  task automatic wait_grant(input int target, input int budget);
    int t = 0;
    while (grant_log.size() < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("grant_wait", 32'(grant_log.size() >= target), 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", 32'(done_cnt >= target), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input logic [1:0] mask, input logic [31:0] addr,
                     input int b, input int e_at, input logic [2:0] e_cd);
    int d0;
    int gl;
    d0 = done_cnt;
    gl = grant_log.size();
    base = b;
    err_at = e_at;
    err_cd = e_cd;
    exp_err = (e_at >= 0);
    exp_cnt = (e_at >= 0) ? e_at : BB;
    exp_code = e_cd;
    bus.req_addr0 = addr;
    bus.req_addr1 = ~addr;
    bus.req_valid = mask;
    wait_grant(gl + 1, 200);
    bus.req_valid = 2'b00;
    wait_done(d0 + 1, 40000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog done_cnt %0d expected progress", done_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int gl;
    int t;
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.byte_ready = 2'b00;
    bus.sd_dout = 8'h00;
    bus.sd_dout_avail = 1'b0;
    bus.sd_busy = 1'b0;
    bus.sd_error = 1'b0;
    bus.sd_error_code = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", bus.req_grant, 0);
    check("rst_bvalid", bus.byte_valid, 0);
    check("rst_bdata", bus.byte_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_ecode", bus.error_code, 0);
    check("rst_active", bus.active, 0);
    check("rst_rd", bus.sd_rd, 0);
    check("rst_addr", bus.sd_addr, 0);
    check("rst_taken", bus.sd_dout_taken, 0);
    @(negedge clk);
    reset = 1'b0;

    // requester 0 alone, address 0x10, bytes 0..255,0..255
    run(2'b01, 32'h0000_0010, 0, -1, 3'b000);

    // simultaneous requests after reset alternate 0,1,0
    pulse_reset();
    d0 = done_cnt;
    gl = grant_log.size();
    base = $urandom_range(0, 255);
    err_at = -1;
    exp_err = 0;
    exp_cnt = BB;
    bus.req_addr0 = $urandom;
    bus.req_addr1 = $urandom;
    bus.req_valid = 2'b11;
    wait_grant(gl + 3, 30000);
    bus.req_valid = 2'b00;
    wait_done(d0 + 3, 40000);
    check("rr_first", grant_log[gl], 0);
    check("rr_second", grant_log[gl+1], 1);
    check("rr_third", grant_log[gl+2], 0);

    // slow consumer: 20 idle cycles before each byte
    slow = 1;
    slow_cnt = 0;
    run(2'b10, $urandom, $urandom_range(0, 255), -1, 3'b000);
    slow = 0;

    // sd_error after 100 bytes with code 010
    run(2'b01, $urandom, $urandom_range(0, 255), 100, 3'b010);
    repeat (3) @(negedge clk);
    check("error_code_hold", bus.error_code, 3'b010);

    // reset at byte 300, then a fresh full read for requester 1
    d0 = done_cnt;
    gl = grant_log.size();
    base = $urandom_range(0, 255);
    err_at = -1;
    exp_err = 0;
    exp_cnt = BB;
    bus.req_addr0 = $urandom;
    bus.req_valid = 2'b01;
    wait_grant(gl + 1, 200);
    bus.req_valid = 2'b00;
    t = 0;
    while (hs < 300 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("reach_byte_300", 32'(hs >= 300), 1);
    reset = 1'b1;
    abort = 1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_rd", bus.sd_rd, 0);
    check("rst_mid_taken", bus.sd_dout_taken, 0);
    check("rst_mid_bvalid", bus.byte_valid, 0);
    check("rst_mid_active", bus.active, 0);
    check("rst_mid_done", bus.done, 0);
    t = 0;
    while (bus.sd_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    abort = 0;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", done_cnt, d0);
    run(2'b10, $urandom, $urandom_range(0, 255), -1, 3'b000);

    // random request patterns, some with sd errors
    for (int k = 0; k < 6; k++) begin
      logic [1:0] m;
      int ea;
      m = 2'($urandom_range(1, 3));
      ea = ($urandom_range(0, 2) == 0) ? $urandom_range(0, BB - 1) : -1;
      run(m, $urandom, $urandom_range(0, 255), ea,
          3'($urandom_range(1, 6)));
    end

`ifdef SD_READ_ARB_TIMEOUT_EN
    // sd_busy never rises: timeout after TO cycles of sd_rd
    never_busy = 1;
    run(2'b01, $urandom, 0, 0, 3'b111);
    check("timeout_rd_len", rd_len, TO);
    never_busy = 0;
`endif

    check("total_grants_vs_done", 32'(grant_log.size()), 32'(done_cnt + 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
